// File: rtl/seg7_pkg.sv
// Shared definitions for seven-segment display drivers: segment patterns,
// the hex-to-segment lookup and the digit-index encoding.
package seg7_pkg;

    typedef enum logic {
        DIG_LO = 1'b0,
        DIG_HI = 1'b1
    } dig_idx_t;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b1111100;
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] pattern;
        pattern = SEG_BLANK;
        case (nibble)
            4'h0: pattern = SEG_0;
            4'h1: pattern = SEG_1;
            4'h2: pattern = SEG_2;
            4'h3: pattern = SEG_3;
            4'h4: pattern = SEG_4;
            4'h5: pattern = SEG_5;
            4'h6: pattern = SEG_6;
            4'h7: pattern = SEG_7;
            4'h8: pattern = SEG_8;
            4'h9: pattern = SEG_9;
            4'hA: pattern = SEG_A;
            4'hB: pattern = SEG_B;
            4'hC: pattern = SEG_C;
            4'hD: pattern = SEG_D;
            4'hE: pattern = SEG_E;
            4'hF: pattern = SEG_F;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble-to-segment decoder, hex digits 0-F.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seg7_mux_drv.sv
// Two-digit multiplexed hex display driver with per-slot ghosting blank and
// frame-synchronous double buffering of the displayed value.
module seg7_mux_drv
    import seg7_pkg::*;
#(
    parameter logic [15:0] REFRESH_DIV  = 16'd10000,
    parameter logic [15:0] BLANK_CYCLES = 16'd100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic [1:0] flags_in,
    input  logic       load,
    input  logic       lz_blank,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] dig_en,
    output logic       busy
);

    logic [15:0] cnt;
    dig_idx_t    idx;
    logic [7:0]  shown_data;
    logic [1:0]  shown_flags;
    logic [7:0]  pend_data;
    logic [1:0]  pend_flags;
    logic        pend_v;

    logic        slot_end;
    logic        frame_end;
    logic [3:0]  nibble;
    logic [6:0]  dec_seg;
    logic [1:0]  dig_en_nxt;
    logic [6:0]  seg_nxt;
    logic        dp_nxt;

    assign slot_end  = (cnt == REFRESH_DIV - 16'd1);
    assign frame_end = slot_end && (idx == DIG_HI);
    assign busy      = pend_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= DIG_LO;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == DIG_LO) ? DIG_HI : DIG_LO;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // A load landing on the frame boundary skips the pending stage entirely,
    // so it wins over any older pending value and leaves pend_v clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shown_data  <= '0;
            shown_flags <= '0;
            pend_data   <= '0;
            pend_flags  <= '0;
            pend_v      <= 1'b0;
        end else if (frame_end) begin
            if (load) begin
                shown_data  <= data_in;
                shown_flags <= flags_in;
            end else if (pend_v) begin
                shown_data  <= pend_data;
                shown_flags <= pend_flags;
            end
            pend_v <= 1'b0;
        end else if (load) begin
            pend_data  <= data_in;
            pend_flags <= flags_in;
            pend_v     <= 1'b1;
        end
    end

    assign nibble = (idx == DIG_HI) ? shown_data[7:4] : shown_data[3:0];

    seg7_hex_decoder u_dec (
        .nibble (nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        dig_en_nxt = '0;
        seg_nxt    = SEG_BLANK;
        dp_nxt     = 1'b0;
        if (cnt >= BLANK_CYCLES &&
            !(idx == DIG_HI && lz_blank && shown_data[7:4] == 4'h0)) begin
            dig_en_nxt = (idx == DIG_HI) ? 2'b10 : 2'b01;
            seg_nxt    = dec_seg;
            dp_nxt     = (idx == DIG_HI) ? shown_flags[1] : shown_flags[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg    <= '0;
            dp     <= 1'b0;
            dig_en <= '0;
        end else begin
            seg    <= seg_nxt;
            dp     <= dp_nxt;
            dig_en <= dig_en_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_mux_drv.sv
// Directed bench for seg7_mux_drv with REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seg7_mux_drv;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic [1:0] flags_in;
    logic       load;
    logic       lz_blank;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] dig_en;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    seg7_mux_drv #(
        .REFRESH_DIV  (16'd8),
        .BLANK_CYCLES (16'd2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .flags_in (flags_in),
        .load     (load),
        .lz_blank (lz_blank),
        .seg      (seg),
        .dp       (dp),
        .dig_en   (dig_en),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] ref_hex(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
              7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
              7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
              7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
        return t[n];
    endfunction

    // Expected {dp, dig_en, seg} during cycle c after reset release, given the
    // shown value held in state during cycle c-1 (one-cycle output lag).
    function automatic logic [9:0] exp_out(input int c, input logic [7:0] sh,
                                           input logic [1:0] fl, input logic lz);
        int p;
        int slot;
        int w;
        logic [3:0] nib;
        if (c == 0) return '0;
        p    = (c - 1) % 16;
        slot = p / 8;
        w    = p % 8;
        if (w < 2) return '0;
        if (slot == 1 && lz && sh[7:4] == 4'h0) return '0;
        nib = (slot == 1) ? sh[7:4] : sh[3:0];
        return {(slot == 1) ? fl[1] : fl[0], (slot == 1) ? 2'b10 : 2'b01, ref_hex(nib)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        load  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        data_in = '0; flags_in = '0; load = 1'b0; lz_blank = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (seg !== 7'b0) begin n_err++; $display("FAIL reset_seg got %b want 0000000", seg); end
        n_cmp++; if (dp !== 1'b0) begin n_err++; $display("FAIL reset_dp got %b want 0", dp); end
        n_cmp++; if (dig_en !== 2'b00) begin n_err++; $display("FAIL reset_dig_en got %b want 00", dig_en); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_free_run();
        logic [9:0] e;
        lz_blank = 1'b0;
        do_reset();
        for (int c = 0; c <= 33; c++) begin
            e = exp_out(c, 8'h00, 2'b00, 1'b0);
            n_cmp++; if (dig_en !== e[8:7]) begin n_err++; $display("FAIL free_dig_en c=%0d got %b want %b", c, dig_en, e[8:7]); end
            n_cmp++; if (seg !== e[6:0]) begin n_err++; $display("FAIL free_seg c=%0d got %b want %b", c, seg, e[6:0]); end
            n_cmp++; if (dp !== 1'b0) begin n_err++; $display("FAIL free_dp c=%0d got %b want 0", c, dp); end
            @(negedge clk);
        end
    endtask

    task automatic test_load();
        logic [9:0] e;
        lz_blank = 1'b0;
        do_reset();
        for (int c = 0; c <= 33; c++) begin
            e = exp_out(c, (c >= 17) ? 8'hA5 : 8'h00, 2'b00, 1'b0);
            n_cmp++; if (dig_en !== e[8:7]) begin n_err++; $display("FAIL load_dig_en c=%0d got %b want %b", c, dig_en, e[8:7]); end
            n_cmp++; if (seg !== e[6:0]) begin n_err++; $display("FAIL load_seg c=%0d got %b want %b", c, seg, e[6:0]); end
            n_cmp++; if (busy !== (c >= 4 && c <= 15)) begin n_err++; $display("FAIL load_busy c=%0d got %b want %b", c, busy, (c >= 4 && c <= 15)); end
            if (c == 19) begin
                n_cmp++; if (seg !== 7'b1101101) begin n_err++; $display("FAIL load_digit0_5 got %b want 1101101", seg); end
            end
            if (c == 27) begin
                n_cmp++; if (seg !== 7'b1110111) begin n_err++; $display("FAIL load_digit1_A got %b want 1110111", seg); end
            end
            load = (c == 3); data_in = 8'hA5; flags_in = 2'b00;
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    task automatic test_back_to_back_bypass();
        logic [9:0] e;
        lz_blank = 1'b0;
        do_reset();
        for (int c = 0; c <= 33; c++) begin
            e = exp_out(c, (c >= 17) ? 8'h3C : 8'h00, 2'b00, 1'b0);
            n_cmp++; if (dig_en !== e[8:7]) begin n_err++; $display("FAIL bypass_dig_en c=%0d got %b want %b", c, dig_en, e[8:7]); end
            n_cmp++; if (seg !== e[6:0]) begin n_err++; $display("FAIL bypass_seg c=%0d got %b want %b", c, seg, e[6:0]); end
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bypass_busy c=%0d got %b want 0", c, busy); end
            if (c == 19) begin
                n_cmp++; if (seg !== 7'b0111001) begin n_err++; $display("FAIL bypass_digit0_C got %b want 0111001", seg); end
            end
            load = (c == 15); data_in = 8'h3C; flags_in = 2'b00;
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    task automatic test_overwrite();
        logic [9:0] e;
        lz_blank = 1'b0;
        do_reset();
        for (int c = 0; c <= 33; c++) begin
            e = exp_out(c, (c >= 17) ? 8'hFF : 8'h00, 2'b00, 1'b0);
            n_cmp++; if (dig_en !== e[8:7]) begin n_err++; $display("FAIL ovw_dig_en c=%0d got %b want %b", c, dig_en, e[8:7]); end
            n_cmp++; if (seg !== e[6:0]) begin n_err++; $display("FAIL ovw_seg c=%0d got %b want %b", c, seg, e[6:0]); end
            if (c == 19 || c == 27) begin
                n_cmp++; if (seg !== 7'b1110001) begin n_err++; $display("FAIL ovw_digit_F c=%0d got %b want 1110001", c, seg); end
            end
            load = (c == 3 || c == 8);
            data_in = (c == 3) ? 8'h11 : 8'hFF;
            flags_in = 2'b00;
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    task automatic test_lz_blank();
        logic [9:0] e;
        logic [7:0] v;
        for (int pass = 0; pass < 2; pass++) begin
            v = (pass == 0) ? 8'h07 : 8'h17;
            lz_blank = 1'b1;
            do_reset();
            for (int c = 0; c <= 33; c++) begin
                e = exp_out(c, (c >= 17) ? v : 8'h00, 2'b00, 1'b1);
                n_cmp++; if (dig_en !== e[8:7]) begin n_err++; $display("FAIL lz_dig_en v=%h c=%0d got %b want %b", v, c, dig_en, e[8:7]); end
                n_cmp++; if (seg !== e[6:0]) begin n_err++; $display("FAIL lz_seg v=%h c=%0d got %b want %b", v, c, seg, e[6:0]); end
                if (c == 20) begin
                    n_cmp++; if (seg !== 7'b0000111) begin n_err++; $display("FAIL lz_digit0_7 v=%h got %b want 0000111", v, seg); end
                end
                if (c == 28) begin
                    n_cmp++; if (dig_en !== ((pass == 0) ? 2'b00 : 2'b10)) begin n_err++; $display("FAIL lz_digit1_en v=%h got %b want %b", v, dig_en, (pass == 0) ? 2'b00 : 2'b10); end
                    if (pass == 1) begin
                        n_cmp++; if (seg !== 7'b0000110) begin n_err++; $display("FAIL lz_digit1_1 got %b want 0000110", seg); end
                    end
                end
                load = (c == 3); data_in = v; flags_in = 2'b00;
                @(negedge clk);
            end
            load = 1'b0;
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_flags_reset();
        logic [9:0] e;
        lz_blank = 1'b0;
        do_reset();
        for (int c = 0; c <= 28; c++) begin
            e = exp_out(c, 8'h00, (c >= 17) ? 2'b10 : 2'b00, 1'b0);
            n_cmp++; if (dp !== e[9]) begin n_err++; $display("FAIL flags_dp c=%0d got %b want %b", c, dp, e[9]); end
            n_cmp++; if (dig_en !== e[8:7]) begin n_err++; $display("FAIL flags_dig_en c=%0d got %b want %b", c, dig_en, e[8:7]); end
            load = (c == 3 || c == 20);
            data_in  = (c == 3) ? 8'h00 : 8'h99;
            flags_in = (c == 3) ? 2'b10 : 2'b11;
            @(negedge clk);
        end
        load = 1'b0;
        // cycle 29: digit 1 lit with carry dp, newer value still pending
        n_cmp++; if (dp !== 1'b1) begin n_err++; $display("FAIL flags_dp_pre_rst got %b want 1", dp); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL flags_busy_pre_rst got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (seg !== 7'b0) begin n_err++; $display("FAIL midrst_seg got %b want 0000000", seg); end
        n_cmp++; if (dp !== 1'b0) begin n_err++; $display("FAIL midrst_dp got %b want 0", dp); end
        n_cmp++; if (dig_en !== 2'b00) begin n_err++; $display("FAIL midrst_dig_en got %b want 00", dig_en); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            e = exp_out(c, 8'h00, 2'b00, 1'b0);
            n_cmp++; if (seg !== e[6:0]) begin n_err++; $display("FAIL postrst_seg c=%0d got %b want %b", c, seg, e[6:0]); end
            n_cmp++; if (dp !== 1'b0) begin n_err++; $display("FAIL postrst_dp c=%0d got %b want 0", c, dp); end
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL postrst_busy c=%0d got %b want 0", c, busy); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_load();
        test_back_to_back_bypass();
        test_overwrite();
        test_lz_blank();
        test_flags_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
